// File: rtl/leds_pio_pkg.sv
// Shared constants for the blinking LED PIO.
// Register word addresses and STATUS bit positions.
package leds_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_MASK   = 3'd4;
  localparam logic [2:0] ADDR_DIV    = 3'd5;
  localparam logic [2:0] ADDR_POL    = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/leds_pio_blink_timer.sv
// Blink phase generator: half-period counter plus phase flop.
// DIV of zero parks the phase high; a DIV write restarts the period.
module leds_pio_blink_timer #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 div_wr,
  output logic                 phase
);

  logic [DIV_WIDTH-1:0] count;

  // Count to DIV-1, then wrap and flip the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b1;
    end else if (div_wr || div == '0) begin
      count <= '0;
      phase <= 1'b1;
    end else if (count == div - 1'b1) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/leds_pio_blink.sv
// Avalon-MM output PIO with atomic set/clear/toggle and per-channel blink.
// Optional output polarity register enabled by LEDS_PIO_INVERT_EN.
module leds_pio_blink
  import leds_pio_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter int               DIV_WIDTH   = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             blink_phase
);

  logic [WIDTH-1:0]     data;
  logic [WIDTH-1:0]     mask;
  logic [DIV_WIDTH-1:0] div;
  logic [WIDTH-1:0]     pol;
  logic [WIDTH-1:0]     wd;
  logic                 wr;
  logic                 sel_data;
  logic                 sel_set;
  logic                 sel_clr;
  logic                 sel_tgl;
  logic                 sel_mask;
  logic                 sel_div;
  logic                 phase;
  logic                 unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = &{1'b0, writedata};

  assign sel_data = wr && address == ADDR_DATA;
  assign sel_set  = wr && address == ADDR_SET;
  assign sel_clr  = wr && address == ADDR_CLEAR;
  assign sel_tgl  = wr && address == ADDR_TOGGLE;
  assign sel_mask = wr && address == ADDR_MASK;
  assign sel_div  = wr && address == ADDR_DIV;

  leds_pio_blink_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .div    (div),
    .div_wr (sel_div),
    .phase  (phase)
  );

  assign blink_phase = phase;

  // Register file writes, including atomic DATA updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
      mask <= '0;
      div  <= '0;
    end else begin
      unique case (1'b1)
        sel_data: data <= wd;
        sel_set:  data <= data | wd;
        sel_clr:  data <= data & ~wd;
        sel_tgl:  data <= data ^ wd;
        sel_mask: mask <= wd;
        sel_div:  div  <= writedata[DIV_WIDTH-1:0];
        default: ;
      endcase
    end
  end

`ifdef LEDS_PIO_INVERT_EN
  // Output polarity register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pol <= '0;
    end else if (wr && address == ADDR_POL) begin
      pol <= wd;
    end
  end
`else
  assign pol = '0;
`endif

  // Output pins: masked channels gated by phase, then polarity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else begin
      out_port <= (data & (~mask | {WIDTH{phase}})) ^ pol;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA,
      ADDR_SET,
      ADDR_CLEAR,
      ADDR_TOGGLE: readdata[WIDTH-1:0] = data;
      ADDR_MASK:   readdata[WIDTH-1:0] = mask;
      ADDR_DIV:    readdata[DIV_WIDTH-1:0] = div;
      ADDR_POL:    readdata[WIDTH-1:0] = pol;
      ADDR_STATUS: readdata[STATUS_PHASE_BIT] = phase;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_leds_pio_blink.sv
// Directed bench for leds_pio_blink (WIDTH=10, RESET_VALUE=10'h155).
// Polarity checks included when LEDS_PIO_INVERT_EN is defined.
module tb_leds_pio_blink;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;
  logic        blink_phase;

  int checks;
  int errors;

  leds_pio_blink #(
    .WIDTH      (10),
    .DIV_WIDTH  (24),
    .RESET_VALUE(10'h155)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .blink_phase(blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_port !== 10'h155) begin
      errors++;
      $display("FAIL reset_out got %h exp 155", out_port);
    end
    reset_n = 1'b1;
    @(negedge clk);
    rd(3'd0, d);
    checks++;
    if (d !== 32'h155) begin
      errors++;
      $display("FAIL reset_data got %h exp 155", d);
    end
    rd(3'd7, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL reset_status got %h exp 1", d);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_mask got %h exp 0", d);
    end
    checks++;
    if (out_port !== 10'h155) begin
      errors++;
      $display("FAIL reset_out2 got %h exp 155", out_port);
    end
  endtask

  task automatic test_atomic;
    logic [2:0]  a[4]    = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] v[4]    = '{32'h0F0, 32'h003, 32'h010, 32'h300};
    logic [9:0]  e[4]    = '{10'h0F0, 10'h0F3, 10'h0E3, 10'h3E3};
    logic [9:0]  prev;
    logic [31:0] d;
    prev = 10'h155;
    for (int i = 0; i < 4; i++) begin
      wr(a[i], v[i]);
      checks++;
      if (out_port !== prev) begin
        errors++;
        $display("FAIL atomic_lat%0d got %h exp %h", i, out_port, prev);
      end
      @(negedge clk);
      checks++;
      if (out_port !== e[i]) begin
        errors++;
        $display("FAIL atomic_out%0d got %h exp %h", i, out_port, e[i]);
      end
      prev = e[i];
    end
    for (int i = 0; i < 4; i++) begin
      rd(a[i], d);
      checks++;
      if (d !== 32'h3E3) begin
        errors++;
        $display("FAIL atomic_rd%0d got %h exp 3e3", i, d);
      end
    end
  endtask

  task automatic test_blink;
    logic [31:0] d;
    logic        ph;
    logic        pv;
    logic [9:0]  eo;
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h00F);
    wr(3'd5, 32'd4);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      ph = ((k / 4) % 2) == 0;
      pv = (k == 0) ? 1'b1 : (((k - 1) / 4) % 2) == 0;
      eo = pv ? 10'h3FF : 10'h3F0;
      rd(3'd7, d);
      checks++;
      if (d !== {31'd0, ph} || blink_phase !== ph) begin
        errors++;
        $display("FAIL blink_ph k=%0d got %h exp %h", k, d, ph);
      end
      checks++;
      if (out_port !== eo) begin
        errors++;
        $display("FAIL blink_out k=%0d got %h exp %h", k, out_port, eo);
      end
    end
  endtask

  task automatic test_div_rewrite;
    logic [31:0] d;
    logic        ph;
    logic        pv;
    logic [9:0]  eo;
    wr(3'd5, 32'd2);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      ph = ((k / 2) % 2) == 0;
      pv = (k == 0) ? 1'b1 : (((k - 1) / 2) % 2) == 0;
      eo = pv ? 10'h3FF : 10'h3F0;
      rd(3'd7, d);
      checks++;
      if (d !== {31'd0, ph}) begin
        errors++;
        $display("FAIL div2_ph k=%0d got %h exp %h", k, d, ph);
      end
      if (k > 0) begin
        checks++;
        if (out_port !== eo) begin
          errors++;
          $display("FAIL div2_out k=%0d got %h exp %h", k, out_port, eo);
        end
      end
    end
    wr(3'd5, 32'd0);
    wr(3'd0, 32'h005);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd(3'd7, d);
      checks++;
      if (d !== 32'h1 || out_port !== 10'h005) begin
        errors++;
        $display("FAIL div0 k=%0d got st=%h out=%h exp st=1 out=005",
                 k, d, out_port);
      end
    end
  endtask

  task automatic test_width;
    logic [31:0] d;
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, d);
    checks++;
    if (d !== 32'h3FF) begin
      errors++;
      $display("FAIL wide_data got %h exp 3ff", d);
    end
    wr(3'd4, 32'hFFFF_FFFF);
    rd(3'd4, d);
    checks++;
    if (d !== 32'h3FF) begin
      errors++;
      $display("FAIL wide_mask got %h exp 3ff", d);
    end
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, d);
    checks++;
    if (d !== 32'h00FF_FFFF) begin
      errors++;
      $display("FAIL wide_div got %h exp ffffff", d);
    end
    wr(3'd5, 32'd0);
    wr(3'd7, 32'h0);
    rd(3'd7, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL status_ro got %h exp 1", d);
    end
    wr(3'd6, 32'h3FF);
    rd(3'd6, d);
    checks++;
`ifdef LEDS_PIO_INVERT_EN
    if (d !== 32'h3FF) begin
      errors++;
      $display("FAIL pol_rd got %h exp 3ff", d);
    end
`else
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL pol_rd got %h exp 0", d);
    end
`endif
    wr(3'd6, 32'h0);
    wr(3'd4, 32'h0);
  endtask

  task automatic test_pol_reset;
    logic [31:0] d;
    logic [9:0]  lo;
`ifdef LEDS_PIO_INVERT_EN
    wr(3'd0, 32'h0);
    wr(3'd6, 32'h001);
    @(negedge clk);
    checks++;
    if (out_port !== 10'h001) begin
      errors++;
      $display("FAIL pol_out got %h exp 001", out_port);
    end
    lo = 10'h001;
`else
    lo = 10'h000;
`endif
    wr(3'd0, 32'h3FF);
    wr(3'd4, 32'h3FF);
    wr(3'd5, 32'd3);
    repeat (4) @(negedge clk);
    checks++;
    if (out_port !== lo) begin
      errors++;
      $display("FAIL midblink_out got %h exp %h", out_port, lo);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 10'h155) begin
      errors++;
      $display("FAIL async_out got %h exp 155", out_port);
    end
    rd(3'd7, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL async_status got %h exp 1", d);
    end
    rd(3'd5, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL async_div got %h exp 0", d);
    end
    rd(3'd6, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL async_pol got %h exp 0", d);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_port !== 10'h155) begin
      errors++;
      $display("FAIL post_reset_out got %h exp 155", out_port);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_atomic();
    test_blink();
    test_div_rewrite();
    test_width();
    test_pol_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
